// File: rtl/systolicarray_2_loader_if.sv
// ============================================================================
// Module   : systolicarray_2_loader_if
// Brief    : Serial element stream (data/valid/ready) into the operand loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface systolicarray_2_loader_if #(
  parameter int SIZE = 8
) ();
  logic [SIZE-1:0] in_data;
  logic            in_valid;
  logic            in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

`default_nettype wire

// File: rtl/systolicarray_2_loader.sv
// ============================================================================
// Module   : systolicarray_2_loader
// Brief    : Packs 8 serial elements onto the 2x2 systolic array's mi0/mi1
//            buses, sequences its reset and flags done after RUN_CYCLES.
//            Optional LOADER_INT2FIX_EN: integer input scaled by DECIMAL and
//            saturated before storage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module systolicarray_2_loader #(
  parameter int SIZE       = 8,
`ifdef LOADER_INT2FIX_EN
  parameter int DECIMAL    = 4,
`endif
  parameter int RUN_CYCLES = 6
) (
  input  wire                        clk,
  input  wire                        rst,
  systolicarray_2_loader_if.slave    s_in,
  input  wire                        clear,
  output logic [4*SIZE-1:0]          mi0,
  output logic [4*SIZE-1:0]          mi1,
  output logic                       arr_rst,
  output logic                       busy,
  output logic                       done
);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] C_RUN_LAST = 8'(RUN_CYCLES - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [2:0]          r_idx;
  logic [7:0]          r_run_cnt;
  logic [4*SIZE-1:0]   r_mi0;
  logic [4*SIZE-1:0]   r_mi1;
  logic                r_in_ready;
  logic                w_accept;
  logic                w_arr_rst;
  logic                w_busy;
  logic                w_done;
  logic [SIZE-1:0]     w_elem;

`ifdef LOADER_INT2FIX_EN
  localparam int C_WW = SIZE + DECIMAL;

  logic [C_WW-1:0] w_wide;
  logic            w_fits;

  // Sign-extend then shift: the result is exact, so only the range check remains.
  assign w_wide = {{DECIMAL{s_in.in_data[SIZE-1]}}, s_in.in_data} << DECIMAL;
  assign w_fits = (&w_wide[C_WW-1:SIZE-1]) | ~(|w_wide[C_WW-1:SIZE-1]);
  assign w_elem = w_fits        ? w_wide[SIZE-1:0] :
                  w_wide[C_WW-1] ? {1'b1, {(SIZE-1){1'b0}}} :
                                   {1'b0, {(SIZE-1){1'b1}}};
`else
  assign w_elem = s_in.in_data;
`endif

  assign w_accept = s_in.in_valid & r_in_ready & ~clear & (r_state == S_LOAD);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_arr_rst   = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    if (clear) begin
      w_state_nxt = S_LOAD;
    end else begin
      case (r_state)
        S_LOAD: if (w_accept && (r_idx == 3'd7)) w_state_nxt = S_RUN;
        S_RUN:  if (r_run_cnt == C_RUN_LAST)      w_state_nxt = S_DONE;
        S_DONE: w_state_nxt = S_DONE;
        default: w_state_nxt = S_LOAD;
      endcase
    end
    case (r_state)
      S_RUN: begin
        w_arr_rst = 1'b1;
        w_busy    = 1'b1;
      end
      S_DONE: begin
        w_arr_rst = 1'b1;
        w_done    = 1'b1;
      end
      default: ;
    endcase
  end

  // in_ready is registered so it stays low for the first cycle out of reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_idx      <= 3'd0;
      r_run_cnt  <= 8'd0;
      r_mi0      <= '0;
      r_mi1      <= '0;
      r_in_ready <= 1'b0;
    end else if (clear) begin
      r_idx      <= 3'd0;
      r_run_cnt  <= 8'd0;
      r_mi0      <= '0;
      r_mi1      <= '0;
      r_in_ready <= 1'b1;
    end else begin
      r_in_ready <= (w_state_nxt == S_LOAD);
      r_run_cnt  <= (r_state == S_RUN) ? r_run_cnt + 8'd1 : 8'd0;
      if (w_accept) begin
        if (!r_idx[2]) begin
          r_mi0[r_idx[1:0]*SIZE +: SIZE] <= w_elem;
        end else begin
          r_mi1[r_idx[1:0]*SIZE +: SIZE] <= w_elem;
        end
        r_idx <= r_idx + 3'd1;
      end
    end
  end

  assign s_in.in_ready = r_in_ready;
  assign mi0           = r_mi0;
  assign mi1           = r_mi1;
  assign arr_rst       = w_arr_rst;
  assign busy          = w_busy;
  assign done          = w_done;

endmodule

`default_nettype wire

// File: tb/tb_systolicarray_2_loader.sv
// ============================================================================
// Module   : tb_systolicarray_2_loader
// Brief    : Directed plus randomized checks of the operand loader against a
//            timestamp-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_systolicarray_2_loader;

  localparam int SIZE       = 8;
  localparam int RUN_CYCLES = 6;

`ifdef LOADER_INT2FIX_EN
  localparam logic [31:0] C_V2_MI0 = 32'h7F7F7F7F;
  localparam logic [31:0] C_V2_MI1 = 32'h7F7F7F7F;
  localparam logic [31:0] C_V6_MI0 = 32'h7F302010;
  localparam logic [31:0] C_V6_MI1 = 32'h70F00080;
`else
  localparam logic [31:0] C_V2_MI0 = 32'h08101008;
  localparam logic [31:0] C_V2_MI1 = 32'h40302010;
  localparam logic [31:0] C_V6_MI0 = 32'h09030201;
  localparam logic [31:0] C_V6_MI1 = 32'h07FF00F7;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] mi0;
  logic [31:0] mi1;
  logic        arr_rst;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  systolicarray_2_loader_if #(.SIZE(SIZE)) u_if ();

  systolicarray_2_loader #(
    .SIZE       (SIZE),
    .RUN_CYCLES (RUN_CYCLES)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .s_in    (u_if),
    .clear   (clear),
    .mi0     (mi0),
    .mi1     (mi1),
    .arr_rst (arr_rst),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] conv(input logic [7:0] d);
`ifdef LOADER_INT2FIX_EN
    int v;
    v = $signed(d) * 16;
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
    return v[7:0];
`else
    return d;
`endif
  endfunction

  // Reference model: list of stored elements plus the edge index of the 8th accept.
  int         cyc = 0;
  int         m_n = 0;
  int         m_rel = 0;
  bit         m_ready = 1'b0;
  bit         m_live = 1'b0;
  logic [7:0] m_el [8];

  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      m_n = 0; m_rel = 0; m_ready = 1'b0; m_live = 1'b1;
      for (int i = 0; i < 8; i++) m_el[i] = 8'h00;
    end else if (clear) begin
      m_n = 0; m_rel = 0; m_ready = 1'b1;
      for (int i = 0; i < 8; i++) m_el[i] = 8'h00;
    end else begin
      if (m_ready && u_if.in_valid && m_n < 8) begin
        m_el[m_n] = conv(u_if.in_data);
        m_n++;
        if (m_n == 8) m_rel = cyc;
      end
      m_ready = (m_n < 8);
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      bit e_arr, e_done;
      e_arr  = (m_n == 8);
      e_done = e_arr && ((cyc - m_rel) >= RUN_CYCLES);
      check("in_ready", u_if.in_ready, m_ready);
      check("arr_rst", arr_rst, e_arr);
      check("busy", busy, e_arr && !e_done);
      check("done", done, e_done);
      check("mi0", mi0, {m_el[3], m_el[2], m_el[1], m_el[0]});
      check("mi1", mi1, {m_el[7], m_el[6], m_el[5], m_el[4]});
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge following the 8th accepting edge.
  task automatic load8(input logic [7:0] v [8], input bit gaps);
    for (int i = 0; i < 8; i++) begin
      bit acc;
      int tries;
      if (gaps) begin
        u_if.in_valid = 1'b0;
        step(1);
      end
      acc = 1'b0;
      tries = 0;
      while (!acc && tries < 20) begin
        u_if.in_valid = 1'b1;
        u_if.in_data  = v[i];
        acc = u_if.in_ready;
        step(1);
        tries++;
      end
      if (!acc) check("load_timeout", 0, 1);
    end
    u_if.in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 50) begin
      step(1);
      n++;
    end
    check(name, n, RUN_CYCLES);
  endtask

  logic [7:0] v2 [8] = '{8'h08, 8'h10, 8'h10, 8'h08, 8'h10, 8'h20, 8'h30, 8'h40};
  logic [7:0] v6 [8] = '{8'h01, 8'h02, 8'h03, 8'h09, 8'hF7, 8'h00, 8'hFF, 8'h07};
  logic [7:0] vr [8];

  initial begin
    u_if.in_valid = 1'b0;
    u_if.in_data  = 8'h00;
    rst = 1'b0;
    step(2);
    check("rst_in_ready", u_if.in_ready, 0);
    check("rst_mi0", mi0, 0);
    check("rst_arr_rst", arr_rst, 0);
    rst = 1'b1;
    step(1);
    check("rel_in_ready", u_if.in_ready, 1);
    check("rel_arr_rst", arr_rst, 0);

    load8(v2, 1'b0);
    check("t2_arr_rst", arr_rst, 1);
    check("t2_mi0", mi0, C_V2_MI0);
    check("t2_mi1", mi1, C_V2_MI1);
    wait_done("t2_done_latency");

    // Input held active in DONE must be ignored.
    u_if.in_valid = 1'b1;
    u_if.in_data  = 8'hFF;
    step(5);
    u_if.in_valid = 1'b0;
    check("t5_done", done, 1);
    check("t5_mi0", mi0, C_V2_MI0);
    check("t5_mi1", mi1, C_V2_MI1);

    clear = 1'b1; step(1); clear = 1'b0;
    load8(v2, 1'b1);
    check("t3_arr_rst", arr_rst, 1);
    check("t3_mi0", mi0, C_V2_MI0);
    wait_done("t3_done_latency");

    clear = 1'b1; step(1); clear = 1'b0;
    load8(v6, 1'b0);
    step(2);
    clear = 1'b1; step(1); clear = 1'b0;
    check("t4_arr_rst", arr_rst, 0);
    check("t4_busy", busy, 0);
    check("t4_mi0", mi0, 0);
    check("t4_in_ready", u_if.in_ready, 1);
    load8(v6, 1'b1);
    check("t6_mi0", mi0, C_V6_MI0);
    check("t6_mi1", mi1, C_V6_MI1);
    wait_done("t4_done_latency");

    // Clear coinciding with a valid element drops it.
    clear = 1'b1; step(1);
    u_if.in_valid = 1'b1; u_if.in_data = 8'h5A;
    step(1);
    clear = 1'b0; u_if.in_valid = 1'b0;
    step(1);
    check("clr_drop_mi0", mi0, 0);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 8; i++) vr[i] = 8'($urandom);
      clear = 1'b1; step(1); clear = 1'b0;
      load8(vr, r[0]);
      wait_done("rnd_done_latency");
    end

    for (int c = 0; c < 2000; c++) begin
      clear         = ($urandom % 25) == 0;
      rst           = ($urandom % 400) != 0;
      u_if.in_valid = ($urandom % 4) != 0;
      u_if.in_data  = 8'($urandom);
      step(1);
    end
    rst = 1'b1; clear = 1'b0; u_if.in_valid = 1'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
